clause_dispatch_ctrl: RTL and testbench
=======================================

// Module: clause_dispatch_ctrl
// PURPOSE
//  Sequencer that streams a preloaded clause table into the clause arbiter, which fans clauses out to the BCP engines.
//  Fetches clauses from a synchronous clause memory into an in-order staging window of up to NUM_ENGINE entries.
//  Presents the window to the arbiter and retires however many clauses the arbiter accepts each cycle.
//  Pulses done once every clause of the current batch has been accepted.
// PARAMETERS
//  NUM_ENGINE   4     number of engines; staging window depth
//  CLA_WIDTH    33    bits per clause (3 literals x 11 bits)
//  CLAUSE_MAX   1024  maximum clauses per batch; ADDR_W = $clog2(CLAUSE_MAX), CNT_W = $clog2(NUM_ENGINE)+1
// PORTS
//  clock           in   1                          clock, rising edge
//  reset           in   1                          synchronous, active-high
//  start_in        in   1                          begin a batch; sampled only in IDLE
//  num_clause_in   in   ADDR_W+1                   clauses in the batch; latched with start_in
//  mem_rd_en       out  1                          clause memory read request
//  mem_rd_addr     out  ADDR_W                     read address, sequential from 0
//  mem_rd_data     in   CLA_WIDTH                  read data, valid the cycle after mem_rd_en
//  window_out      out  [NUM_ENGINE][CLA_WIDTH]    staged clauses; [0] is the oldest
//  window_cnt_out  out  CNT_W                      number of valid window entries (0..NUM_ENGINE)
//  arb_start_out   out  1                          window offered to the arbiter
//  accept_in       in   CNT_W                      clauses the arbiter consumed this cycle, taken from [0] upward
//  busy_out        out  1                          state != IDLE
//  done_out        out  1                          one-cycle pulse, batch complete
//  error_out       out  1                          sticky: accept_in exceeded window_cnt_out
// BEHAVIOUR
//  Reset: state IDLE; all of the following cleared: fetch_ptr, rd_pending, window contents, window_cnt, error.
//   All outputs are 0 during and after reset. Reset mid-batch aborts it; returning read data is discarded.
//  FSM states and transitions:
//   IDLE  -> RUN   on start_in with num_clause_in != 0; latch total and clear error.
//   IDLE  -> DONE  on start_in with num_clause_in == 0.
//   RUN   -> DRAIN when fetch_ptr == total and rd_pending == 0.
//   DRAIN -> DONE  when the next window_cnt == 0.
//   DONE  -> IDLE  unconditionally; done_out = (state == DONE).
//  start_in outside IDLE is ignored.
//  Fetch (RUN only):
//   mem_rd_en = (fetch_ptr < total) && (window_cnt + rd_pending < NUM_ENGINE).
//   mem_rd_addr = fetch_ptr[ADDR_W-1:0]; fetch_ptr increments on each issued read.
//   rd_pending is a register = previous cycle's mem_rd_en, so at most one read is in flight.
//   Same-cycle accept is not credited when deciding fetch (conservative), so the window never overflows.
//  Window update (every edge):
//   acc_eff = arb_start_out ? min(accept_in, window_cnt) : 0.
//   Shift entries down by acc_eff; if rd_pending, write mem_rd_data at index window_cnt - acc_eff.
//   window_cnt_next = window_cnt - acc_eff + rd_pending. Accept and append in the same cycle are legal.
//   Entries at or above window_cnt are driven 0.
//  Outputs:
//   arb_start_out = (RUN or DRAIN) && window_cnt != 0.
//   accept_in > window_cnt while arb_start_out: clamp and set error_out; error holds until the next accepted start.
//   accept_in while arb_start_out == 0 is ignored and does not set error.
//  Latency: start at edge t -> RUN and first rd_en (addr 0) in cycle t+1 -> data in cycle t+2 -> window_cnt = 1 in cycle t+3.
//  Ordering: clauses leave window_out[0..] in strictly increasing address order.
// TESTING
//  1. num_clause=6, accept_in = window_cnt each cycle -> reads addr 0..5 once each; accepted data in address order;
//     sum of acc_eff = 6; a single done_out pulse; busy_out then drops.
//  2. num_clause=10, accept_in = 0 for 12 cycles -> window_cnt saturates at 4; rd_en low; fetch_ptr = 4;
//     then accept 1/cycle -> completes with order preserved.
//  3. num_clause=0 -> done_out high exactly in cycle t+1; no mem_rd_en ever.
//  4. window_cnt = 3, accept_in = 5 -> window_cnt = 0 next cycle; error_out = 1 until the next start.
//  5. Reset asserted mid-RUN with rd_pending = 1 -> next cycle all outputs 0 and state IDLE;
//     a fresh start of 2 clauses completes normally.
//  6. start_in pulsed while busy, plus accept_in = 2 while arb_start_out = 0 -> both ignored;
//     batch completes unchanged; error_out stays 0.

Source files
------------

// File: rtl/clause_dispatch_ctrl.sv
// Streams a preloaded clause table into an in-order window of up to NUM_ENGINE entries for the arbiter.
// First read one cycle after start, data lands in the window two cycles later; fetch stalls while window plus in-flight read is full.
module clause_dispatch_ctrl #(
  parameter int NUM_ENGINE = 4,
  parameter int CLA_WIDTH  = 33,
  parameter int CLAUSE_MAX = 1024,
  localparam int ADDR_W    = $clog2(CLAUSE_MAX),
  localparam int CNT_W     = $clog2(NUM_ENGINE) + 1
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  start_in,
  input  logic [ADDR_W:0]                       num_clause_in,
  output logic                                  mem_rd_en,
  output logic [ADDR_W-1:0]                     mem_rd_addr,
  input  logic [CLA_WIDTH-1:0]                  mem_rd_data,
  output logic [NUM_ENGINE-1:0][CLA_WIDTH-1:0]  window_out,
  output logic [CNT_W-1:0]                      window_cnt_out,
  output logic                                  arb_start_out,
  input  logic [CNT_W-1:0]                      accept_in,
  output logic                                  busy_out,
  output logic                                  done_out,
  output logic                                  error_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W:0] ENG = (CNT_W+1)'(NUM_ENGINE);

  state_t                                state;
  state_t                                state_nxt;
  logic [ADDR_W:0]                       total;
  logic [ADDR_W:0]                       fetch_ptr;
  logic                                  rd_pending;
  logic [NUM_ENGINE-1:0][CLA_WIDTH-1:0]  win;
  logic [NUM_ENGINE-1:0][CLA_WIDTH-1:0]  win_nxt;
  logic [CNT_W-1:0]                      cnt;
  logic [CNT_W-1:0]                      cnt_nxt;
  logic [CNT_W-1:0]                      acc_eff;
  logic [CNT_W-1:0]                      wr_idx;
  logic                                  error_q;
  logic                                  rd_en;
  logic                                  arb_start;
  logic                                  over_accept;
  logic                                  start_run;

  // Fetch ignores same-cycle accepts, so window plus in-flight read never exceeds NUM_ENGINE.
  always_comb begin
    rd_en       = (state == RUN) && (fetch_ptr < total) &&
                  (({1'b0, cnt} + {{CNT_W{1'b0}}, rd_pending}) < ENG);
    arb_start   = ((state == RUN) || (state == DRAIN)) && (cnt != '0);
    over_accept = arb_start && (accept_in > cnt);
    if (!arb_start) begin
      acc_eff = '0;
    end else if (over_accept) begin
      acc_eff = cnt;
    end else begin
      acc_eff = accept_in;
    end
    wr_idx  = cnt - acc_eff;
    cnt_nxt = cnt - acc_eff + {{(CNT_W-1){1'b0}}, rd_pending};
  end

  // Slots at or above cnt always hold zero, so shifting them down keeps the tail clean.
  always_comb begin
    win_nxt = '0;
    for (int i = 0; i < NUM_ENGINE; i++) begin
      for (int j = 0; j < NUM_ENGINE; j++) begin
        if (CNT_W'(j) == CNT_W'(i) + acc_eff) begin
          win_nxt[i] = win[j];
        end
      end
      if (rd_pending && (wr_idx == CNT_W'(i))) begin
        win_nxt[i] = mem_rd_data;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    start_run = 1'b0;
    case (state)
      IDLE: begin
        if (start_in) begin
          if (num_clause_in != '0) begin
            state_nxt = RUN;
            start_run = 1'b1;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      RUN: begin
        if ((fetch_ptr == total) && !rd_pending) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_nxt == '0) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      total      <= '0;
      fetch_ptr  <= '0;
      rd_pending <= 1'b0;
      win        <= '0;
      cnt        <= '0;
      error_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      win        <= win_nxt;
      cnt        <= cnt_nxt;
      rd_pending <= rd_en;
      if (start_run) begin
        total     <= num_clause_in;
        fetch_ptr <= '0;
      end else if (rd_en) begin
        fetch_ptr <= fetch_ptr + 1'b1;
      end
      if (start_run) begin
        error_q <= 1'b0;
      end else if (over_accept) begin
        error_q <= 1'b1;
      end
    end
  end

  // Outputs are forced low while reset is held so nothing stale leaks out mid-abort.
  always_comb begin
    mem_rd_en      = !reset && rd_en;
    mem_rd_addr    = reset ? '0 : fetch_ptr[ADDR_W-1:0];
    window_out     = reset ? '0 : win;
    window_cnt_out = reset ? '0 : cnt;
    arb_start_out  = !reset && arb_start;
    busy_out       = !reset && (state != IDLE);
    done_out       = !reset && (state == DONE);
    error_out      = !reset && error_q;
  end

  a_cnt_bound: assert property (@(posedge clock) disable iff (reset)
    ({1'b0, cnt} <= ENG));
  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    (({1'b0, cnt} + {{CNT_W{1'b0}}, rd_pending}) <= ENG));

endmodule

// File: tb/tb_clause_dispatch_ctrl.sv
// Randomized and directed bench for clause_dispatch_ctrl against a queue-based reference model.
module tb_clause_dispatch_ctrl;

  localparam int NE = 4;
  localparam int CW = 33;
  localparam int AW = 10;
  localparam int KW = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  logic                  clock;
  logic                  reset;
  logic                  start_in;
  logic [AW:0]           num_clause_in;
  logic                  mem_rd_en;
  logic [AW-1:0]         mem_rd_addr;
  logic [CW-1:0]         mem_rd_data;
  logic [NE-1:0][CW-1:0] window_out;
  logic [KW-1:0]         window_cnt_out;
  logic                  arb_start_out;
  logic [KW-1:0]         accept_in;
  logic                  busy_out;
  logic                  done_out;
  logic                  error_out;

  clause_dispatch_ctrl dut (
    .clock(clock), .reset(reset), .start_in(start_in), .num_clause_in(num_clause_in),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .window_out(window_out), .window_cnt_out(window_cnt_out), .arb_start_out(arb_start_out),
    .accept_in(accept_in), .busy_out(busy_out), .done_out(done_out), .error_out(error_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nchecks = 0;
  int nfail   = 0;

  task automatic check(input string nm, input logic [131:0] act, input logic [131:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Clause memory: one-cycle read latency, garbage when not read.
  logic [CW-1:0] mem [1024];
  always @(posedge clock) begin
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    else           mem_rd_data <= r[CW-1:0];
  end

  // Reference model: window as a queue, counters as plain ints.
  int            m_state = M_IDLE;
  int            m_total = 0;
  int            m_fptr  = 0;
  bit            m_pend  = 0;
  int            m_paddr = 0;
  bit            m_err   = 0;
  logic [CW-1:0] m_win[$];

  always @(posedge clock) begin
    if (reset) begin
      m_state = M_IDLE; m_total = 0; m_fptr = 0; m_pend = 0; m_err = 0;
      m_win.delete();
    end else begin
      bit rd;
      int acc;
      rd  = (m_state == M_RUN) && (m_fptr < m_total) && (m_win.size() + int'(m_pend) < NE);
      acc = 0;
      if ((m_state == M_RUN || m_state == M_DRAIN) && m_win.size() != 0) begin
        if (int'(accept_in) > m_win.size()) begin
          acc   = m_win.size();
          m_err = 1;
        end else begin
          acc = int'(accept_in);
        end
      end
      repeat (acc) void'(m_win.pop_front());
      if (m_pend) m_win.push_back(mem[m_paddr]);
      case (m_state)
        M_IDLE: if (start_in) begin
          if (num_clause_in != 0) begin
            m_state = M_RUN; m_total = int'(num_clause_in); m_fptr = 0; m_err = 0;
          end else begin
            m_state = M_DONE;
          end
        end
        M_RUN:   if (m_fptr == m_total && !m_pend) m_state = M_DRAIN;
        M_DRAIN: if (m_win.size() == 0) m_state = M_DONE;
        default: m_state = M_IDLE;
      endcase
      m_pend  = rd;
      m_paddr = m_fptr;
      if (rd) m_fptr++;
    end
  end

  // Observation logs used by the directed checks.
  int            rd_log[$];
  logic [CW-1:0] acc_log[$];
  int            acc_sum  = 0;
  int            done_cnt = 0;

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    logic [NE-1:0][CW-1:0] ew;
    bit e_rd, e_arb;
    int k;
    ew = '0;
    if (reset) begin
      check("rst_rd_en", mem_rd_en, 0);
      check("rst_window", window_out, 0);
      check("rst_cnt", window_cnt_out, 0);
      check("rst_arb", arb_start_out, 0);
      check("rst_busy", busy_out, 0);
      check("rst_done", done_out, 0);
      check("rst_err", error_out, 0);
    end else begin
      for (int i = 0; i < m_win.size(); i++) ew[i] = m_win[i];
      e_rd  = (m_state == M_RUN) && (m_fptr < m_total) && (m_win.size() + int'(m_pend) < NE);
      e_arb = (m_state == M_RUN || m_state == M_DRAIN) && m_win.size() != 0;
      check("rd_en", mem_rd_en, e_rd);
      if (e_rd) check("rd_addr", mem_rd_addr, m_fptr);
      check("window", window_out, ew);
      check("window_cnt", window_cnt_out, m_win.size());
      check("arb_start", arb_start_out, e_arb);
      check("busy", busy_out, m_state != M_IDLE);
      check("done", done_out, m_state == M_DONE);
      check("error", error_out, m_err);
    end
    if (mem_rd_en) rd_log.push_back(int'(mem_rd_addr));
    if (done_out) done_cnt++;
    if (arb_start_out) begin
      k = (accept_in > window_cnt_out) ? int'(window_cnt_out) : int'(accept_in);
      for (int j = 0; j < k; j++) acc_log.push_back(window_out[j]);
      acc_sum += k;
    end
  end

  // 0 none, 1 all, 2 one, 3 random, 4 two-when-idle-else-all, 9 manual
  int acc_mode = 0;

  task automatic apply_acc();
    case (acc_mode)
      0: accept_in = '0;
      1: accept_in = window_cnt_out;
      2: accept_in = 3'd1;
      3: accept_in = 3'($urandom_range(0, 5));
      4: accept_in = arb_start_out ? window_cnt_out : 3'd2;
      default: ;
    endcase
  endtask

  task automatic step();
    @(posedge clock);
    #2;
    apply_acc();
  endtask

  task automatic clr();
    rd_log.delete(); acc_log.delete(); acc_sum = 0; done_cnt = 0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy_out && n < 300) begin
      step();
      n++;
    end
    check({nm, "_timeout"}, n < 300, 1);
  endtask

  task automatic start_batch(input int num);
    num_clause_in = 11'(num);
    start_in = 1'b1;
    step();
    start_in = 1'b0;
  endtask

  task automatic check_seq(input string nm, input int n);
    check({nm, "_reads"}, rd_log.size(), n);
    for (int i = 0; i < rd_log.size() && i < n; i++) check({nm, "_rd_addr"}, rd_log[i], i);
    check({nm, "_accepted"}, acc_log.size(), n);
    for (int i = 0; i < acc_log.size() && i < n; i++) check({nm, "_order"}, acc_log[i], mem[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", nchecks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    int n;
    for (int i = 0; i < 1024; i++) begin
      r = {$urandom(), $urandom()};
      mem[i] = r[CW-1:0];
    end
    reset = 1'b1; start_in = 1'b0; num_clause_in = '0; accept_in = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("reset_busy", busy_out, 0);
    check("reset_cnt", window_cnt_out, 0);

    // Empty batch: done exactly one cycle after start, no reads.
    clr(); acc_mode = 0;
    start_batch(0);
    check("t3_done_t1", done_out, 1);
    check("t3_rd_en", mem_rd_en, 0);
    wait_idle("t3");
    check("t3_done_cnt", done_cnt, 1);
    check("t3_reads", rd_log.size(), 0);

    // Six clauses, arbiter takes everything offered.
    clr(); acc_mode = 1;
    start_batch(6);
    check("t1_rd_en_t1", mem_rd_en, 1);
    check("t1_rd_addr_t1", mem_rd_addr, 0);
    step();
    check("t1_cnt_t2", window_cnt_out, 0);
    step();
    check("t1_cnt_t3", window_cnt_out, 1);
    check("t1_win0_t3", window_out[0], mem[0]);
    wait_idle("t1");
    check_seq("t1", 6);
    check("t1_acc_sum", acc_sum, 6);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_busy_after", busy_out, 0);

    // Ten clauses with a stalled arbiter, then one per cycle.
    clr(); acc_mode = 0;
    start_batch(10);
    repeat (11) step();
    check("t2_cnt_sat", window_cnt_out, 4);
    check("t2_rd_en_stall", mem_rd_en, 0);
    check("t2_fetched", rd_log.size(), 4);
    acc_mode = 2; apply_acc();
    wait_idle("t2");
    check_seq("t2", 10);
    check("t2_done_cnt", done_cnt, 1);

    // Over-accept: three in window, arbiter claims five.
    clr(); acc_mode = 0;
    start_batch(3);
    n = 0;
    while (window_cnt_out != 3 && n < 20) begin step(); n++; end
    check("t4_fill_timeout", n < 20, 1);
    acc_mode = 9; accept_in = 3'd5;
    step();
    check("t4_cnt_cleared", window_cnt_out, 0);
    check("t4_error_set", error_out, 1);
    accept_in = '0; acc_mode = 0;
    wait_idle("t4");
    check("t4_error_sticky", error_out, 1);

    // Start while busy and accept while not offering are both ignored.
    clr(); acc_mode = 4;
    start_batch(5);
    check("t6_error_cleared", error_out, 0);
    num_clause_in = 11'd7; start_in = 1'b1;
    step(); step();
    start_in = 1'b0;
    wait_idle("t6");
    check_seq("t6", 5);
    check("t6_error", error_out, 0);
    check("t6_done_cnt", done_cnt, 1);

    // Reset with a read in flight, then a clean two-clause batch.
    clr(); acc_mode = 0;
    start_batch(8);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("t5_rd_en", mem_rd_en, 0);
    check("t5_addr", mem_rd_addr, 0);
    check("t5_window", window_out, 0);
    check("t5_cnt", window_cnt_out, 0);
    check("t5_arb", arb_start_out, 0);
    check("t5_busy", busy_out, 0);
    check("t5_done", done_out, 0);
    step();
    clr(); acc_mode = 1;
    start_batch(2);
    wait_idle("t5");
    check_seq("t5", 2);
    check("t5_done_cnt", done_cnt, 1);

    // Random batches with random accepts, stray starts and occasional resets.
    acc_mode = 3;
    for (int b = 0; b < 40; b++) begin
      start_batch($urandom_range(0, 12));
      n = 0;
      while (busy_out && n < 300) begin
        start_in = ($urandom_range(0, 30) == 0);
        num_clause_in = 11'($urandom_range(0, 12));
        if ($urandom_range(0, 150) == 0) begin
          reset = 1'b1;
          step();
          reset = 1'b0;
        end else begin
          step();
        end
        n++;
      end
      start_in = 1'b0;
      check("rand_timeout", n < 300, 1);
      step();
    end
    acc_mode = 0; accept_in = '0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
